regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NREQ  3   number of write-back requesters
  AW    6   register address width (64 registers)
  DW    32  register data width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk           in   1        single clock, all state updates on rising edge
  rst           in   1        reset, synchronous, active-high
  stall         in   1        freeze: no grants while high
  req_valid     in   NREQ     requester i has a write pending
  req_addr      in   NREQ*AW  requester i destination address, slice [i*AW +: AW]
  req_data      in   NREQ*DW  requester i write data, slice [i*DW +: DW]
  req_ready     out  NREQ     one-hot grant; transfer when valid[i] & ready[i]
  alloc_valid   in   1        mark a register as pending a write
  alloc_addr    in   AW       register to mark
  we            out  1        register-file write enable
  wa            out  AW       register-file write address
  wd            out  DW       register-file write data
  busy          out  2**AW    scoreboard, bit n = register n pending
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from req_valid, stall, rst and the priority pointer.
REQ-005 Arbitration SHALL be round-robin: search order starts at pointer ptr (0..NREQ-1) and wraps; first valid requester is granted.
REQ-006 After a grant to requester g, ptr SHALL become (g+1) mod NREQ; with no grant ptr SHALL hold.
REQ-007 While stall=1 or rst=1, req_ready SHALL be all zero and ptr SHALL hold (reset value applies under rst).
REQ-008 A requester SHALL hold valid, addr, data stable until accepted; the bench asserts this, the block does not check it.
REQ-009 Write latency SHALL be one cycle: on the edge after acceptance, we=1, wa=accepted addr, wd=accepted data, for exactly one cycle per transfer.
REQ-010 In any cycle with no transfer, the next-cycle we SHALL be 0; wa/wd SHALL hold their last values.
REQ-011 Back-to-back transfers SHALL produce we=1 on consecutive cycles with no bubble; sustained throughput one write per cycle.
REQ-012 Consecutive transfers to the same address SHALL both be written, in grant order (last one wins in the register file).
REQ-013 busy[alloc_addr] SHALL be set at the edge where alloc_valid=1.
REQ-014 busy[a] SHALL clear at the same edge that loads the output register with a transfer to address a (i.e. busy drops as we rises).
REQ-015 Simultaneous alloc and clear of the same address SHALL leave busy=1 (new producer wins).
REQ-016 Writes to addresses with busy=0 SHALL be performed normally; no error flag.
REQ-017 NREQ=1 SHALL degenerate to ready=valid&~stall&~rst with ptr constant 0.

Reset
REQ-018 With rst=1 at a rising edge: we=0, wa=0, wd=0, ptr=0, busy all zero.
REQ-019 A transfer presented in a cycle with rst=1 SHALL NOT be accepted and SHALL NOT produce a write; reset mid-stream discards nothing already on we/wa/wd beyond clearing them.
REQ-020 First grant after reset release SHALL go to the lowest-index valid requester.

Verification
REQ-021 Single write: after reset, valid=001, addr0=5, data0=0xDEADBEEF -> ready=001 same cycle; next cycle we=1, wa=5, wd=0xDEADBEEF; following cycle we=0.
REQ-022 Fairness: all three valid continuously, distinct addrs 1,2,3 -> grant order 0,1,2,0,1,2; we=1 every cycle; no requester waits more than 2 cycles.
REQ-023 Stall: all valid, stall=1 for 4 cycles -> ready=000, we=0 after first stalled cycle, ptr unchanged; on release, grant resumes at held ptr.
REQ-024 Scoreboard: alloc addr 7, later requester 1 writes addr 7 -> busy[7]=1 from edge after alloc until edge that asserts we with wa=7; same-edge alloc 7 plus write 7 -> busy[7] stays 1.
REQ-025 Reset mid-operation: rst=1 while requesters 0 and 2 valid and we=1 -> next cycle we=0, wa=0, wd=0, busy=0; after release, requester 0 granted first.
REQ-026 Same-address ordering: requester 0 writes 9 <- 0x1, requester 1 writes 9 <- 0x2, both valid -> we on two consecutive cycles, wd=0x1 then 0x2.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter feeding one register-file write port, with a pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 6,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr,
  output logic                 we,
  output logic [AW-1:0]        wa,
  output logic [DW-1:0]        wd,
  output logic [2**AW-1:0]     busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int BW = 2**AW;
  logic [PW-1:0] ptr, gidx;
  logic          hit;
  int            j;
  logic [AW-1:0] sa;
  logic [DW-1:0] sd;
  logic [BW-1:0] clr, set;
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!hit && req_valid[j] && !stall && !rst) begin
        hit  = 1'b1;
        gidx = PW'(j);
      end
    end
    req_ready = hit ? NREQ'(1) << gidx : '0;
  end
  assign sa  = req_addr[gidx*AW +: AW];
  assign sd  = req_data[gidx*DW +: DW];
  assign clr = hit ? BW'(1) << sa : '0;
  assign set = alloc_valid ? BW'(1) << alloc_addr : '0;
  // a same-edge alloc overrides the clear, so the newer producer keeps the bit
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
      busy <= '0;
    end else begin
      we   <= hit;
      busy <= (busy & ~clr) | set;
      if (hit) begin
        ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
        wa  <= sa;
        wd  <= sd;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus random traffic checked against a cycle-level reference model
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3, AW = 6, DW = 32;
  logic clk = 0, rst, stall, alloc_valid, we;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [AW-1:0] alloc_addr, wa;
  logic [DW-1:0] wd;
  logic [63:0] busy;
  int total = 0, bad = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .we(we), .wa(wa), .wd(wd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, stall;
    logic [2:0] valid;
    logic [17:0] addr;
    logic [95:0] data;
    logic alloc;
    logic [5:0] aaddr;
    logic [2:0] ready;
    logic we;
    logic [5:0] wa;
    logic [31:0] wd;
    logic b7;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic [2:0] v, logic [17:0] a, logic [95:0] d,
                              logic al, logic [5:0] aa, logic [2:0] rdy, logic w,
                              logic [5:0] xa, logic [31:0] xd, logic b);
    vec_t t;
    t.rst = r; t.stall = s; t.valid = v; t.addr = a; t.data = d; t.alloc = al; t.aaddr = aa;
    t.ready = rdy; t.we = w; t.wa = xa; t.wd = xd; t.b7 = b;
    return t;
  endfunction

  // reference model: arbitration pointer, pending set and the write port
  int m_ptr = 0, m_g;
  bit [63:0] m_busy = 0;
  bit m_we = 0;
  bit [5:0] m_wa = 0;
  bit [31:0] m_wd = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (rst || stall) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic step(bit has_exp, vec_t v);
    logic [2:0] er;
    #4;
    m_g = pick();
    er = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
    chk("ready_model", 64'(req_ready), 64'(er));
    if (has_exp) chk("ready_vec", 64'(req_ready), 64'(v.ready));
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_busy = 0;
    end else begin
      m_we = (m_g >= 0);
      if (m_g >= 0) begin
        m_wa = req_addr[m_g*AW +: AW];
        m_wd = req_data[m_g*DW +: DW];
        m_busy[m_wa] = 1'b0;
        m_ptr = (m_g + 1) % NREQ;
      end
      if (alloc_valid) m_busy[alloc_addr] = 1'b1;
    end
    #1;
    chk("we_model", 64'(we), 64'(m_we));
    chk("wa_model", 64'(wa), 64'(m_wa));
    chk("wd_model", 64'(wd), 64'(m_wd));
    chk("busy_model", busy, m_busy);
    if (has_exp) begin
      chk("we_vec", 64'(we), 64'(v.we));
      chk("wa_vec", 64'(wa), 64'(v.wa));
      chk("wd_vec", 64'(wd), 64'(v.wd));
      chk("busy7_vec", 64'(busy[7]), 64'(v.b7));
    end
  endtask

  initial begin
    logic [17:0] a5, a123, a99, a406, a7;
    logic [95:0] d5, d123, d12, d406, d7;
    a5 = {12'd0, 6'd5};              d5 = {64'd0, 32'hDEADBEEF};
    a123 = {6'd3, 6'd2, 6'd1};       d123 = {32'hC, 32'hB, 32'hA};
    a99 = {6'd0, 6'd9, 6'd9};        d12 = {32'd0, 32'd2, 32'd1};
    a406 = {6'd4, 6'd0, 6'd6};       d406 = {32'h44, 32'd0, 32'h66};
    a7 = {6'd0, 6'd7, 6'd0};         d7 = {32'd0, 32'h77, 32'd0};
    // request during reset is refused, then a single write
    tbl.push_back(mk(1, 0, 3'b001, a5, d5, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, a5, d5, 0, 0, 3'b001, 1, 5, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 3'b000, a5, d5, 0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 0));
    // fairness: continuous requests rotate 0,1,2 with a write every cycle
    tbl.push_back(mk(1, 0, 3'b000, a5, d5, 0, 0, 3'b000, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(0, 0, 3'b111, a123, d123, 0, 0, 3'(1 << (k % 3)), 1, 6'(k % 3 + 1), 32'(k % 3 + 10), 0));
    // stall freezes grants and pointer; resumes at requester 1
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 1, 3'b111, a123, d123, 0, 0, 3'b000, 0, 1, 32'hA, 0));
    tbl.push_back(mk(0, 0, 3'b111, a123, d123, 0, 0, 3'b010, 1, 2, 32'hB, 0));
    // same-address ordering
    tbl.push_back(mk(1, 0, 3'b000, a99, d12, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b011, a99, d12, 0, 0, 3'b001, 1, 9, 1, 0));
    tbl.push_back(mk(0, 0, 3'b010, a99, d12, 0, 0, 3'b010, 1, 9, 2, 0));
    tbl.push_back(mk(0, 0, 3'b000, a99, d12, 0, 0, 3'b000, 0, 9, 2, 0));
    // reset mid-stream clears outputs and busy, then requester 0 wins
    tbl.push_back(mk(0, 0, 3'b101, a406, d406, 1, 7, 3'b100, 1, 4, 32'h44, 1));
    tbl.push_back(mk(0, 0, 3'b101, a406, d406, 0, 0, 3'b001, 1, 6, 32'h66, 1));
    tbl.push_back(mk(1, 0, 3'b101, a406, d406, 0, 0, 3'b000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b101, a406, d406, 0, 0, 3'b001, 1, 6, 32'h66, 0));
    tbl.push_back(mk(0, 0, 3'b100, a406, d406, 0, 0, 3'b100, 1, 4, 32'h44, 0));
    // scoreboard: set by alloc, cleared by write, alloc wins on a same-edge collision
    tbl.push_back(mk(0, 0, 3'b000, a7, d7, 1, 7, 3'b000, 0, 4, 32'h44, 1));
    tbl.push_back(mk(0, 0, 3'b000, a7, d7, 0, 0, 3'b000, 0, 4, 32'h44, 1));
    tbl.push_back(mk(0, 0, 3'b010, a7, d7, 0, 0, 3'b010, 1, 7, 32'h77, 0));
    tbl.push_back(mk(0, 0, 3'b010, a7, d7, 1, 7, 3'b010, 1, 7, 32'h77, 1));
    tbl.push_back(mk(0, 0, 3'b000, a7, d7, 0, 0, 3'b000, 0, 7, 32'h77, 1));

    rst = 1; stall = 0; req_valid = 0; req_addr = 0; req_data = 0; alloc_valid = 0; alloc_addr = 0;
    @(posedge clk); #1;
    foreach (tbl[n]) begin
      rst = tbl[n].rst; stall = tbl[n].stall; req_valid = tbl[n].valid;
      req_addr = tbl[n].addr; req_data = tbl[n].data;
      alloc_valid = tbl[n].alloc; alloc_addr = tbl[n].aaddr;
      step(1, tbl[n]);
    end

    // random traffic: each requester holds its request until it is granted
    req_valid = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = 6'($urandom_range(15));
          req_data[i*DW +: DW] = $urandom;
        end
      stall = ($urandom_range(4) == 0);
      rst = ($urandom_range(39) == 0);
      alloc_valid = ($urandom_range(2) == 0);
      alloc_addr = 6'($urandom_range(15));
      step(0, tbl[0]);
      if (m_g >= 0) req_valid[m_g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
